// File: rtl/trapezoid_filter_v2.sv
// trapezoid_filter_v2
// Runtime-reconfigurable trapezoidal (k, l, M) pulse shaper for the ADC
// filter chain. Sits between the ADC sample register and the peak/energy
// extraction logic.
//
//   d(n) = x(n) - x(n-k) - x(n-l) + x(n-k-l)
//   p(n) = p(n-1) + d(n)
//   r(n) = p(n) + M*d(n)
//   s(n) = s(n-1) + r(n)
//   out  = s >>> SHIFT
//
// Ports
//   clk       rising-edge clock
//   reset_n   synchronous active-low reset
//   in_valid  sample strobe
//   in_data   signed input sample
//   cfg_we    config write strobe (wins over in_valid in the same cycle)
//   cfg_k/l/m new k, l and M; legal iff 1 <= k <= l <= DEPTH
//   cfg_err   one-cycle pulse after a rejected config write
//   primed    k+l samples accepted since last reset/legal config
//   out_valid output strobe, five cycles after the accepted sample
//   out_data  shaped sample, held between strobes
//
// Build option
//   TRAP_SATURATE_EN  defined: out_data clamps to the signed output range.
//                     undefined: out_data keeps the low bits (wraps).
module trapezoid_filter_v2 #(
    parameter int SIZE_IN_DATA  = 14,
    parameter int SIZE_OUT_DATA = 16,
    parameter int SIZE_CNT      = 4,
    parameter int DEPTH         = 14,
    parameter int K_INIT        = 5,
    parameter int L_INIT        = 8,
    parameter int M_INIT        = 16,
    parameter int M_W           = 8,
    parameter int ACC_W         = 40,
    parameter int SHIFT         = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid,
    input  logic signed [SIZE_IN_DATA-1:0]  in_data,
    input  logic                            cfg_we,
    input  logic        [SIZE_CNT-1:0]      cfg_k,
    input  logic        [SIZE_CNT-1:0]      cfg_l,
    input  logic        [M_W-1:0]           cfg_m,
    output logic                            cfg_err,
    output logic                            primed,
    output logic                            out_valid,
    output logic signed [SIZE_OUT_DATA-1:0] out_data
);

    localparam int HIST = 2 * DEPTH;
    localparam int PW   = $clog2(HIST);
    // Two spare bits so pointer + HIST - offset never overflows.
    localparam int IW   = PW + 2;
    localparam logic [SIZE_CNT:0] DEPTH_C = (SIZE_CNT + 1)'(DEPTH);

    logic signed [SIZE_IN_DATA-1:0]  hist_q [HIST];
    logic        [PW-1:0]            ptr_q;
    logic        [SIZE_CNT-1:0]      k_q, l_q;
    logic        [M_W-1:0]           m_q;
    logic        [IW-1:0]            primeCnt_q;
    logic                            cfgErr_q;
    logic                            v1_q, v2_q, v3_q, v4_q, v5_q;
    logic signed [ACC_W-1:0]         d1_q, p_q, md_q, r_q, s_q;
    logic signed [SIZE_OUT_DATA-1:0] outData_q;

    logic                            cfgLegal, accept, flush;
    logic        [IW-1:0]            kl;
    logic signed [SIZE_IN_DATA-1:0]  xk, xl, xkl;
    logic signed [ACC_W-1:0]         d1_d, mExt, shifted;
    logic signed [SIZE_OUT_DATA-1:0] outData_d;

    function automatic logic [PW-1:0] tapIdx(input logic [PW-1:0] ptr,
                                             input logic [IW-1:0] off);
        logic [IW-1:0] sum;
        sum = IW'(ptr) + IW'(HIST) - off;
        if (sum >= IW'(HIST))
            sum = sum - IW'(HIST);
        return PW'(sum);
    endfunction

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [SIZE_IN_DATA-1:0] x);
        return {{(ACC_W - SIZE_IN_DATA){x[SIZE_IN_DATA-1]}}, x};
    endfunction

    assign cfgLegal = (cfg_k != '0) && (cfg_k <= cfg_l) && ({1'b0, cfg_l} <= DEPTH_C);
    assign accept   = in_valid && !cfg_we;
    // A legal config clears the same datapath state that reset does.
    assign flush    = !reset_n || (cfg_we && cfgLegal);
    assign kl       = IW'(k_q) + IW'(l_q);
    assign mExt     = {{(ACC_W - M_W){1'b0}}, m_q};

    // Taps are read before this cycle's write, so an offset of 2*DEPTH lands
    // on the slot about to be overwritten, which is exactly x(n-2*DEPTH).
    always_comb begin
        xk   = hist_q[tapIdx(ptr_q, IW'(k_q))];
        xl   = hist_q[tapIdx(ptr_q, IW'(l_q))];
        xkl  = hist_q[tapIdx(ptr_q, kl)];
        d1_d = sext(in_data) - sext(xk) - sext(xl) + sext(xkl);
    end

    always_comb begin
        shifted = s_q >>> SHIFT;
`ifdef TRAP_SATURATE_EN
        begin
            logic signed [ACC_W-1:0] outMax, outMin, clamped;
            outMax  = {{(ACC_W - SIZE_OUT_DATA + 1){1'b0}}, {(SIZE_OUT_DATA - 1){1'b1}}};
            outMin  = ~outMax;
            clamped = shifted;
            if (shifted > outMax)
                clamped = outMax;
            else if (shifted < outMin)
                clamped = outMin;
            outData_d = SIZE_OUT_DATA'(clamped);
        end
`else
        outData_d = SIZE_OUT_DATA'(shifted);
`endif
    end

    // Configuration, error pulse and output register. out_data survives a
    // config flush (it holds between strobes) but not a reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            k_q       <= SIZE_CNT'(K_INIT);
            l_q       <= SIZE_CNT'(L_INIT);
            m_q       <= M_W'(M_INIT);
            cfgErr_q  <= 1'b0;
            outData_q <= '0;
        end else begin
            cfgErr_q <= cfg_we && !cfgLegal;
            if (cfg_we && cfgLegal) begin
                k_q <= cfg_k;
                l_q <= cfg_l;
                m_q <= cfg_m;
            end
            if (v4_q && !flush)
                outData_q <= outData_d;
        end
    end

    // History, prime counter and the five valid-tracked pipeline stages.
    // Each stage and its accumulator only move when the incoming valid is set.
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < HIST; i++)
                hist_q[i] <= '0;
            ptr_q      <= '0;
            primeCnt_q <= '0;
            {v1_q, v2_q, v3_q, v4_q, v5_q} <= '0;
            d1_q <= '0;
            p_q  <= '0;
            md_q <= '0;
            r_q  <= '0;
            s_q  <= '0;
        end else begin
            if (accept) begin
                hist_q[ptr_q] <= in_data;
                ptr_q         <= (ptr_q == PW'(HIST - 1)) ? '0 : ptr_q + 1'b1;
                if (primeCnt_q < IW'(HIST))
                    primeCnt_q <= primeCnt_q + 1'b1;
                d1_q <= d1_d;
            end
            v1_q <= accept;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
            v5_q <= v4_q;
            if (v1_q) begin
                p_q  <= p_q + d1_q;
                md_q <= d1_q * mExt;
            end
            if (v2_q)
                r_q <= p_q + md_q;
            if (v3_q)
                s_q <= s_q + r_q;
        end
    end

    assign cfg_err   = cfgErr_q;
    assign primed    = (primeCnt_q >= kl);
    assign out_valid = v5_q;
    assign out_data  = outData_q;

endmodule

// File: tb/tb_trapezoid_filter_v2.sv
module tb_trapezoid_filter_v2;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               in_valid;
   logic signed [13:0] in_data;
   logic               cfg_we;
   logic        [3:0]  cfg_k;
   logic        [3:0]  cfg_l;
   logic        [7:0]  cfg_m;
   logic               cfg_err;
   logic               primed;
   logic               out_valid;
   logic signed [15:0] out_data;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic               inValid;
      logic signed [13:0] inData;
      logic               expValid;
      logic signed [15:0] expData;
   } vec_t;

   vec_t impVec[12];
   vec_t defVec[18];
   logic vHist[40];

   // 10 ns clock
   always #5 clk = ~clk;

   trapezoid_filter_v2 #(
      .DEPTH (8),
      .SHIFT (0)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .cfg_we    (cfg_we),
      .cfg_k     (cfg_k),
      .cfg_l     (cfg_l),
      .cfg_m     (cfg_m),
      .cfg_err   (cfg_err),
      .primed    (primed),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   // Drive one cycle of inputs, then sample just after the rising edge
   task automatic applyStimulus(input logic v, input logic signed [13:0] d,
                                input logic we, input logic [3:0] k,
                                input logic [3:0] l, input logic [7:0] m);
      in_valid = v;
      in_data  = d;
      cfg_we   = we;
      cfg_k    = k;
      cfg_l    = l;
      cfg_m    = m;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Impulse response for k=2, l=4, M=0, SHIFT=0
   task automatic playImpulse(input string tag);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(impVec[i].inValid, impVec[i].inData, 1'b0, 4'd0, 4'd0, 8'd0);
         checkOutput($sformatf("%s valid[%0d]", tag, i), out_valid, impVec[i].expValid);
         checkOutput($sformatf("%s data[%0d]", tag, i), $signed(out_data), impVec[i].expData);
      end
   endtask

   // Guard against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish, expected finish before 200000");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int acc;
      logic signed [15:0] impS[8];
      logic signed [15:0] defS[14];
      logic [3:0] badK[3];
      logic [3:0] badL[3];

      // Hand-computed s(n) for impulse 100, k=2 l=4 M=0
      impS = '{16'sd100, 16'sd200, 16'sd200, 16'sd200, 16'sd100, 16'sd0, 16'sd0, 16'sd0};
      // Hand-computed s(n) for impulse 1 with reset defaults k=5 l=8 M=16
      defS = '{16'sd17, 16'sd18, 16'sd19, 16'sd20, 16'sd21, 16'sd5, 16'sd5,
               16'sd5, -16'sd12, -16'sd13, -16'sd14, -16'sd15, -16'sd16, 16'sd0};
      badK = '{4'd0, 4'd1, 4'd5};
      badL = '{4'd4, 4'd9, 4'd3};

      for (int i = 0; i < 12; i++) begin
         impVec[i].inValid  = 1'b1;
         impVec[i].inData   = (i == 0) ? 14'sd100 : 14'sd0;
         impVec[i].expValid = (i >= 4);
         impVec[i].expData  = (i >= 4) ? impS[i-4] : 16'sd0;
      end
      for (int i = 0; i < 18; i++) begin
         defVec[i].inValid  = 1'b1;
         defVec[i].inData   = (i == 0) ? 14'sd1 : 14'sd0;
         defVec[i].expValid = (i >= 4);
         defVec[i].expData  = (i >= 4) ? defS[i-4] : 16'sd0;
      end

      // Reset state
      reset_n = 1'b0;
      applyStimulus(1'b0, 14'sd0, 1'b0, 4'd0, 4'd0, 8'd0);
      applyStimulus(1'b0, 14'sd0, 1'b0, 4'd0, 4'd0, 8'd0);
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset out_data", $signed(out_data), 0);
      checkOutput("reset cfg_err", cfg_err, 0);
      checkOutput("reset primed", primed, 0);
      reset_n = 1'b1;

      // Priming with gaps: 13 accepts on alternate cycles, default k+l=13
      acc = 0;
      for (int c = 0; c < 30; c++) begin
         vHist[c] = ((c % 2) == 0) && (c / 2 < 13);
         applyStimulus(vHist[c], 14'sd0, 1'b0, 4'd0, 4'd0, 8'd0);
         if (vHist[c]) acc++;
         checkOutput($sformatf("prime out_valid[%0d]", c), out_valid, (c >= 4) ? vHist[c-4] : 1'b0);
         checkOutput($sformatf("prime primed[%0d]", c), primed, acc >= 13);
      end

      // Legal config clears primed, then impulse shape
      applyStimulus(1'b0, 14'sd0, 1'b1, 4'd2, 4'd4, 8'd0);
      checkOutput("cfg legal cfg_err", cfg_err, 0);
      checkOutput("cfg legal primed", primed, 0);
      playImpulse("imp");

      // Illegal configs: pulse, primed kept, parameters kept
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 14'sd0, 1'b1, badK[i], badL[i], 8'd200);
         checkOutput($sformatf("illegal%0d cfg_err", i), cfg_err, 1);
         checkOutput($sformatf("illegal%0d primed", i), primed, 1);
         applyStimulus(1'b0, 14'sd0, 1'b0, 4'd0, 4'd0, 8'd0);
         checkOutput($sformatf("illegal%0d cfg_err drop", i), cfg_err, 0);
      end
      playImpulse("postIllegal");

      // Collision mid-stream: config wins, pipeline flushed
      applyStimulus(1'b1, 14'sd100, 1'b0, 4'd0, 4'd0, 8'd0);
      applyStimulus(1'b1, 14'sd0, 1'b0, 4'd0, 4'd0, 8'd0);
      applyStimulus(1'b1, 14'sd0, 1'b0, 4'd0, 4'd0, 8'd0);
      applyStimulus(1'b1, 14'sd55, 1'b1, 4'd2, 4'd4, 8'd0);
      checkOutput("collision cfg_err", cfg_err, 0);
      checkOutput("collision primed", primed, 0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 14'sd0, 1'b0, 4'd0, 4'd0, 8'd0);
         checkOutput($sformatf("flush out_valid[%0d]", i), out_valid, 0);
         checkOutput($sformatf("flush primed[%0d]", i), primed, 0);
      end
      playImpulse("postFlush");

      // Saturation / wrap of a single large sample
      applyStimulus(1'b0, 14'sd0, 1'b1, 4'd5, 4'd8, 8'd255);
      checkOutput("sat cfg_err", cfg_err, 0);
      applyStimulus(1'b1, 14'sd8191, 1'b0, 4'd0, 4'd0, 8'd0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 14'sd0, 1'b0, 4'd0, 4'd0, 8'd0);
      checkOutput("sat out_valid", out_valid, 1);
`ifdef TRAP_SATURATE_EN
      checkOutput("sat out_data", $signed(out_data), 32767);
`else
      checkOutput("sat out_data", $signed(out_data), -256);
`endif

      // Reset in the middle of an impulse
      applyStimulus(1'b0, 14'sd0, 1'b1, 4'd2, 4'd4, 8'd0);
      applyStimulus(1'b1, 14'sd100, 1'b0, 4'd0, 4'd0, 8'd0);
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 14'sd0, 1'b0, 4'd0, 4'd0, 8'd0);
      checkOutput("midpulse out_data", $signed(out_data), 200);
      reset_n = 1'b0;
      applyStimulus(1'b1, 14'sd7, 1'b0, 4'd0, 4'd0, 8'd0);
      reset_n = 1'b1;
      checkOutput("midreset out_valid", out_valid, 0);
      checkOutput("midreset out_data", $signed(out_data), 0);
      checkOutput("midreset primed", primed, 0);
      checkOutput("midreset cfg_err", cfg_err, 0);

      // Defaults restored: response of k=5, l=8, M=16
      for (int i = 0; i < 18; i++) begin
         applyStimulus(defVec[i].inValid, defVec[i].inData, 1'b0, 4'd0, 4'd0, 8'd0);
         checkOutput($sformatf("default valid[%0d]", i), out_valid, defVec[i].expValid);
         checkOutput($sformatf("default data[%0d]", i), $signed(out_data), defVec[i].expData);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
